// File: rtl/seg_display_scanner_pkg.sv
// Shared display constants and helpers used by the scanner and the 7-segment decoder.
package seg_display_scanner_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int IDX_W      = 2;
  localparam int CNT_W      = 16;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [IDX_W-1:0]   idx_t;

  function automatic logic [NUM_DIGITS-1:0] onehot(input idx_t idx);
    logic [NUM_DIGITS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/seg_display_scanner_scan_timer.sv
// Refresh counter: flags the last cycle of a digit slot and whether the next cycle is past dead time.
module scan_timer
  import seg_display_scanner_pkg::*;
#(
  parameter int REFRESH_DIV = 25000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic i_Clk,
  input  logic i_Reset,
  output logic o_Wrap,
  output logic o_Live_Next
);
  logic [CNT_W-1:0] count, count_next;

  // Look-ahead flag lets the enable register line up exactly with count >= DEAD_CYCLES.
  always_comb begin
    o_Wrap      = (count == CNT_W'(REFRESH_DIV - 1));
    count_next  = o_Wrap ? '0 : count + CNT_W'(1);
    o_Live_Next = (count_next >= CNT_W'(DEAD_CYCLES));
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) count <= '0;
    else         count <= count_next;
  end
endmodule

// File: rtl/seg_display_scanner.sv
// Multiplexed 4-digit scanner: holds the digit registers, steps the scan index and drives one-hot enables.
module seg_display_scanner
  import seg_display_scanner_pkg::*;
#(
  parameter int REFRESH_DIV = 25000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Load,
  input  logic [IDX_W-1:0]      i_Load_Index,
  input  logic [DIGIT_W-1:0]    i_Load_Value,
  input  logic [NUM_DIGITS-1:0] i_Blank_Mask,
  output logic [DIGIT_W-1:0]    o_Digit_Value,
  output logic [NUM_DIGITS-1:0] o_Digit_Enable,
  output logic                  o_Scan_Tick
);
  logic wrap, live_next;
  idx_t scan_idx, idx_next;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digit_reg;
  digit_t value_next;
  logic [NUM_DIGITS-1:0] enable_next;

  scan_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_timer (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .o_Wrap      (wrap),
    .o_Live_Next (live_next)
  );

  // A load to the slot being shown bypasses the register so the value updates without a gap.
  always_comb begin
    idx_next    = wrap ? scan_idx + idx_t'(1) : scan_idx;
    value_next  = (i_Load && (i_Load_Index == scan_idx)) ? i_Load_Value : digit_reg[scan_idx];
    enable_next = (live_next && !i_Blank_Mask[idx_next]) ? onehot(idx_next) : '0;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      digit_reg      <= '0;
      scan_idx       <= '0;
      o_Digit_Value  <= '0;
      o_Digit_Enable <= '0;
      o_Scan_Tick    <= 1'b0;
    end else begin
      if (i_Load) digit_reg[i_Load_Index] <= i_Load_Value;
      scan_idx       <= idx_next;
      o_Digit_Value  <= value_next;
      o_Digit_Enable <= enable_next;
      o_Scan_Tick    <= wrap;
    end
  end
endmodule

// File: doc/seg_display_scanner.md
SEG_DISPLAY_SCANNER -- requirements
Module: seg_display_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 25000: clock cycles each digit is driven before the scan advances; legal range 4..65535.
REQ-002 Parameter DEAD_CYCLES, default 2: cycles at the start of each digit slot with all enables low; legal range 2..REFRESH_DIV-1.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 i_Clk  input  1  system clock; all state changes on its rising edge.
REQ-005 i_Reset  input  1  synchronous reset, active-high.
REQ-006 i_Load  input  1  single-cycle write strobe into the digit register file.
REQ-007 i_Load_Index  input  2  digit slot written when i_Load=1.
REQ-008 i_Load_Value  input  4  binary nibble written when i_Load=1.
REQ-009 i_Blank_Mask  input  4  bit n=1 suppresses the enable for digit n; sampled live.
REQ-010 o_Digit_Value  output  4  nibble for the shared registered binary-to-7-segment decoder.
REQ-011 o_Digit_Enable  output  4  one-hot, active-high enable for the physical digit, aligned with the decoder output.
REQ-012 o_Scan_Tick  output  1  one-cycle pulse on every digit-slot advance.

Function
REQ-013 State: a 16-bit refresh counter, a 2-bit scan index, four 4-bit digit registers, and the registered outputs.
REQ-014 Refresh counter increments each cycle and wraps from REFRESH_DIV-1 to 0.
REQ-015 On the wrap cycle, the scan index increments modulo 4 (3 -> 0) and o_Scan_Tick is 1 for exactly the next cycle.
REQ-016 o_Digit_Value is registered and equals digit_reg[scan_index] one cycle after any change of scan_index or of that register.
REQ-017 o_Digit_Enable bit (scan_index) is 1 only when the refresh counter is >= DEAD_CYCLES and i_Blank_Mask[scan_index]=0; all other bits are 0.
REQ-018 Because DEAD_CYCLES >= 2 covers the 1-cycle value register plus the 1-cycle decoder latency, no digit is ever enabled while segments for the previous digit are present.
REQ-019 o_Digit_Enable is never more than one-hot in any cycle.
REQ-020 Loads are accepted every cycle with no backpressure; the write lands on the clock edge where i_Load=1.
REQ-021 Load to the currently scanned slot: the new value appears on o_Digit_Value on the following cycle, with no enable gap.
REQ-022 Load coinciding with a scan wrap: both take effect; if the load targets the new index, o_Digit_Value shows the new value one cycle later.
REQ-023 Blank mask change mid-slot takes effect on o_Digit_Enable on the next cycle.

Reset
REQ-024 While i_Reset=1 at a clock edge: refresh counter=0, scan_index=0, all digit registers=0, o_Digit_Value=0, o_Digit_Enable=0, o_Scan_Tick=0.
REQ-025 Reset mid-slot discards the slot; after release, scanning restarts at digit 0 with a full dead-time period, and loads presented during reset are ignored.

Structure
REQ-026 The digit count (4), value width (4), and index width (2) SHALL be constants in the shared display package, used by this block and the decoder.
REQ-027 The refresh/dead-time counter SHALL be one sub-module, scan_timer, producing the wrap pulse and the dead-time flag; the decoder is instantiated at top level, outside this block.

Verification (bench uses REFRESH_DIV=8, DEAD_CYCLES=2)
REQ-028 Reset, then load 1,2,3,4 into slots 0..3 -> o_Digit_Value cycles 1,2,3,4 in 8-cycle slots; the enable pattern 0001,0010,0100,1000 is high 6 cycles per slot; o_Scan_Tick pulses every 8 cycles.
REQ-029 At every slot boundary, check the first 2 cycles -> o_Digit_Enable=0000; the enable is never high while the decoder output mismatches the slot's value.
REQ-030 i_Blank_Mask=4'b0100 -> slot 2 enable stays 0000 for all 8 cycles; the other slots are unaffected.
REQ-031 Load 4'hA to slot 1 during cycle 5 of slot 1 -> o_Digit_Value=A on cycle 6; the enable stays continuously high.
REQ-032 Assert i_Reset for 1 cycle in the middle of slot 3 -> next cycle all outputs 0, scan_index=0, registers 0; the first enable occurs 2 cycles after release.
REQ-033 Load slot 0 on the 3->0 wrap cycle -> the new value is shown in slot 0 with no stale value, and the enable does not rise before counter=2.
